// File: rtl/sync_filter.sv
// sync_filter: per-channel multi-flop synchroniser followed by a stability
// filter. A channel's output level only follows the synchronised input after
// the input has disagreed with the output for FILT consecutive cycles.
// Registered one-cycle edge pulses and a sticky "glitch" flag that records
// abandoned transitions are produced alongside the filtered level.
//
// Handshake: none. Every input is sampled on each rising I_CLK edge, and every
// output is a flop, so outputs change only just after a rising edge.
module sync_filter #(
  parameter int              CH      = 1,
  parameter int              STAGES  = 2,
  parameter int              FILT    = 1,
  parameter logic [CH-1:0]   RST_VAL = {CH{1'b0}}
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic [CH-1:0] I_D,
  input  logic          I_CLR,
  output logic [CH-1:0] O_Q,
  output logic [CH-1:0] O_RISE,
  output logic [CH-1:0] O_FALL,
  output logic [CH-1:0] O_GLITCH
);

  // Counter width: enough to hold FILT-1, never narrower than one bit.
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  // Terminal count: the value at which a pending transition is accepted.
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------

  // Synchroniser chain. Entry 0 captures the asynchronous input; entry
  // STAGES-1 is the settled sample that the filter looks at.
  logic [CH-1:0] sync_q [STAGES];

  // Filtered level and its next-state value.
  logic [CH-1:0] level_q;
  logic [CH-1:0] level_d;

  // Per-channel run counters: number of consecutive cycles the settled
  // sample has disagreed with the filtered level.
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // Registered edge pulses and sticky glitch flags.
  logic [CH-1:0] rise_q;
  logic [CH-1:0] fall_q;
  logic [CH-1:0] glitch_q;

  // Combinational helpers.
  logic [CH-1:0] settled;
  logic [CH-1:0] glitch_set;
  logic [CH-1:0] rise_d;
  logic [CH-1:0] fall_d;
  logic [CH-1:0] glitch_d;

  assign settled = sync_q[STAGES-1];

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  // ---------------------------------------------------------------------------

  // Plain flop-to-flop shift; nothing sits between stages so each stage gets
  // a full cycle to resolve metastability.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= I_D;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------------

  // Per channel: agreement clears the run (and flags an abandoned run as a
  // glitch); disagreement either extends the run or, at the terminal count,
  // moves the filtered level to the new value. With FILT=1 the terminal
  // count is zero, so any disagreement is accepted at once and no run ever
  // builds up, which means the glitch condition can never be met.
  always_comb begin
    level_d    = level_q;
    glitch_set = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      if (settled[i] == level_q[i]) begin
        glitch_set[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = settled[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge pulses are derived from the level about to be registered, so a
  // pulse is high in exactly the cycle the new level first appears.
  // A glitch in the same cycle as a clear request wins over the clear.
  always_comb begin
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    glitch_d = glitch_set | (glitch_q & ~{CH{I_CLR}});
  end

  // Filter state and output registers; reset discards any pending run and
  // leaves every pulse and flag low.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      level_q  <= RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign O_Q      = level_q;
  assign O_RISE   = rise_q;
  assign O_FALL   = fall_q;
  assign O_GLITCH = glitch_q;

endmodule
